// File: rtl/bs_result_collector.sv
// Result collector: per-core holding registers, round-robin arbiter and a
// first-word-fall-through FIFO feeding one valid/ready result stream.
module bs_result_collector #(
  parameter int BSMODS     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CNTW       = 16,
  localparam int CW        = (BSMODS > 1) ? $clog2(BSMODS) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [BSMODS-1:0]       BS_DONE,
  input  logic [BSMODS-1:0][31:0] ap_return,
  input  logic [BSMODS-1:0][31:0] opt_id,
  output logic [BSMODS-1:0]       slot_free,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [63:0]             res_data,
  output logic [CW-1:0]           res_core,
  output logic [BSMODS-1:0]       overflow,
  output logic [CNTW-1:0]         result_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = 64 + CW;
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(FIFO_DEPTH);

  logic [BSMODS-1:0]       pend;
  logic [BSMODS-1:0][63:0] hold;
  logic [EW-1:0]           mem [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [PW:0]             fifo_count;
  logic [CW-1:0]           rr_ptr;

  logic                    pop;
  logic                    space;
  logic                    grant_vld;
  logic [BSMODS-1:0]       grant_oh;
  logic [CW-1:0]           grant_idx;
  logic [CW-1:0]           rr_next;
  logic [63:0]             grant_data;
  logic [EW-1:0]           head;

  assign head      = mem[rd_ptr];
  assign res_valid = (fifo_count != '0);
  assign res_data  = res_valid ? head[63:0] : '0;
  assign res_core  = res_valid ? head[EW-1:64] : '0;
  assign slot_free = ~pend;
  assign pop       = res_valid & res_ready;
  assign space     = (fifo_count != FULL_COUNT) | pop;

  // Pick the pending core with the smallest wrapped distance from rr_ptr.
  always_comb begin
    int best_d;
    int d;
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    best_d     = BSMODS;
    d          = 0;
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    grant_oh   = '0;
    for (int j = 0; j < BSMODS; j++) begin
      d = j - int'(rr_ptr);
      if (d < 0) d = d + BSMODS;
      if (pend[j] && d < best_d) begin
        best_d     = d;
        grant_idx  = CW'(j);
        grant_data = hold[j];
      end
    end
    grant_vld = space && (best_d < BSMODS);
    for (int j = 0; j < BSMODS; j++) begin
      grant_oh[j] = grant_vld && (grant_idx == CW'(j));
    end
    rr_next = (grant_idx == CW'(BSMODS - 1)) ? '0 : grant_idx + 1'b1;
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend         <= '0;
      hold         <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      rr_ptr       <= '0;
      overflow     <= '0;
      result_count <= '0;
    end else begin
      for (int i = 0; i < BSMODS; i++) begin
        if (BS_DONE[i]) begin
          // A granted slot frees up this edge, so a same-cycle result is kept.
          if (!pend[i] || grant_oh[i]) hold[i] <= {opt_id[i], ap_return[i]};
          else                         overflow[i] <= 1'b1;
        end
      end
      pend <= (pend & ~grant_oh) | BS_DONE;
      if (grant_vld) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= rr_next;
      end
      if (pop) begin
        rd_ptr       <= rd_ptr + 1'b1;
        result_count <= result_count + 1'b1;
      end
      case ({grant_vld, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: the FIFO storage is not reset; fifo_count gates every read, so
  // stale contents are never visible and the array can map to plain RAM.
  always_ff @(posedge clock) begin
    if (grant_vld) mem[wr_ptr] <= {grant_idx, grant_data};
  end

endmodule

// File: tb/tb_bs_result_collector.sv
// Scoreboard bench for bs_result_collector: per-core expected queues filled by
// the stimulus, drained by an independent output monitor.
module tb_bs_result_collector;

  logic             clock;
  logic             reset;
  logic [1:0]       BS_DONE;
  logic [1:0][31:0] ap_return;
  logic [1:0][31:0] opt_id;
  logic [1:0]       slot_free;
  logic             res_valid;
  logic             res_ready;
  logic [63:0]      res_data;
  logic [0:0]       res_core;
  logic [1:0]       overflow;
  logic [15:0]      result_count;

  bs_result_collector #(.BSMODS(2), .FIFO_DEPTH(4), .CNTW(16)) dut (
    .clock(clock), .reset(reset), .BS_DONE(BS_DONE), .ap_return(ap_return),
    .opt_id(opt_id), .slot_free(slot_free), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_core(res_core),
    .overflow(overflow), .result_count(result_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;
  int exp_count = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input int i, input logic [63:0] v);
    if (i == 0) q0.push_back(v);
    else        q1.push_back(v);
    exp_count++;
  endtask

  // Dispatcher behaviour: start a core only while its slot is free.
  task automatic issue(input int i, input logic [31:0] id, input logic [31:0] pr);
    int n = 0;
    while (!slot_free[i] && n < 50) begin
      step();
      n++;
    end
    check($sformatf("slot_wait_core%0d", i), 64'(slot_free[i]), 64'd1);
    if (slot_free[i]) begin
      BS_DONE[i]   = 1'b1;
      opt_id[i]    = id;
      ap_return[i] = pr;
      push_exp(i, {id, pr});
      step();
      BS_DONE = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    BS_DONE = '0;
    step();
    step();
    reset = 1'b0;
    exp_count = 0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    res_ready = 1'b1;
    while ((q0.size() != 0 || q1.size() != 0 || res_valid) && n < 200) begin
      step();
      n++;
    end
    check({name, "_drained"}, 64'(q0.size() + q1.size()), 64'd0);
    check({name, "_count"}, 64'(result_count), 64'(exp_count & 16'hFFFF));
  endtask

  // Output monitor: pops the per-core queue on every transfer and checks
  // that a stalled head does not change.
  initial begin
    logic        held;
    logic [63:0] prev_data;
    logic [0:0]  prev_core;
    logic [63:0] exp;
    held = 1'b0;
    prev_data = '0;
    prev_core = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        q0.delete();
        q1.delete();
        held = 1'b0;
      end else begin
        if (held) begin
          check("head_stable", {res_valid, res_core, res_data[62:0]},
                {1'b1, prev_core, prev_data[62:0]});
        end
        if (res_valid && res_ready) begin
          if (res_core == 1'b0) begin
            check("expected_core0", 64'(q0.size() != 0), 64'd1);
            if (q0.size() != 0) begin
              exp = q0.pop_front();
              check("res_data_core0", res_data, exp);
            end
          end else begin
            check("expected_core1", 64'(q1.size() != 0), 64'd1);
            if (q1.size() != 0) begin
              exp = q1.pop_front();
              check("res_data_core1", res_data, exp);
            end
          end
        end
        held      = res_valid && !res_ready;
        prev_data = res_data;
        prev_core = res_core;
      end
    end
  end

  initial begin
    logic [31:0] p0, p1, rid, rpr;
    reset     = 1'b1;
    BS_DONE   = '0;
    ap_return = '0;
    opt_id    = '0;
    res_ready = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_slot_free", 64'(slot_free), 64'h3);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data", res_data, 64'd0);
    check("rst_res_core", 64'(res_core), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_count", 64'(result_count), 64'd0);

    // Single result: latency T+2, slot busy only in T+1
    res_ready = 1'b1;
    BS_DONE[0] = 1'b1;
    opt_id[0] = 32'h0000_0011;
    ap_return[0] = 32'h42C8_0000;
    push_exp(0, 64'h0000_0011_42C8_0000);
    step();
    BS_DONE = '0;
    check("single_t1_slot_free", 64'(slot_free), 64'h2);
    check("single_t1_valid", 64'(res_valid), 64'd0);
    step();
    check("single_t2_valid", 64'(res_valid), 64'd1);
    check("single_t2_data", res_data, 64'h0000_0011_42C8_0000);
    check("single_t2_core", 64'(res_core), 64'd0);
    check("single_t2_slot_free", 64'(slot_free), 64'h3);
    step();
    check("single_count", 64'(result_count), 64'd1);
    check("single_t3_valid", 64'(res_valid), 64'd0);

    // Simultaneous completion, twice: rr_ptr must return to core 0 first
    do_reset();
    res_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      p0 = $urandom;
      p1 = $urandom;
      BS_DONE = 2'b11;
      opt_id[0] = 32'hA; ap_return[0] = p0;
      opt_id[1] = 32'hB; ap_return[1] = p1;
      push_exp(0, {32'hA, p0});
      push_exp(1, {32'hB, p1});
      step();
      BS_DONE = '0;
      check("simul_t1_slot_free", 64'(slot_free), 64'h0);
      step();
      check("simul_t2_core", 64'(res_core), 64'd0);
      check("simul_t2_data", res_data, {32'hA, p0});
      check("simul_t2_slot_free", 64'(slot_free), 64'h1);
      step();
      check("simul_t3_core", 64'(res_core), 64'd1);
      check("simul_t3_data", res_data, {32'hB, p1});
      step();
      check("simul_t4_valid", 64'(res_valid), 64'd0);
    end
    check("simul_overflow", 64'(overflow), 64'd0);
    check("simul_count", 64'(result_count), 64'(exp_count));

    // Back-pressure: 6 alternating results with the output stalled
    res_ready = 1'b0;
    for (int k = 0; k < 6; k++) issue(k % 2, 32'h100 + 32'(k), $urandom);
    step();
    step();
    check("bp_slot_free", 64'(slot_free), 64'h0);
    check("bp_valid", 64'(res_valid), 64'd1);
    drain("bp");

    // Overflow: FIFO full, core 1 held, second core-1 result dropped
    res_ready = 1'b0;
    for (int k = 0; k < 4; k++) issue(k % 2, 32'h200 + 32'(k), $urandom);
    issue(1, 32'h55, $urandom);
    step();
    step();
    check("ovf_pre_slot_free", 64'(slot_free), 64'h1);
    check("ovf_pre_overflow", 64'(overflow), 64'd0);
    BS_DONE[1] = 1'b1;
    opt_id[1] = 32'h99;
    ap_return[1] = $urandom;
    step();
    BS_DONE = '0;
    check("ovf_flag", 64'(overflow), 64'h2);
    step();
    drain("ovf");
    check("ovf_sticky", 64'(overflow), 64'h2);

    // Grant and recapture of core 0 in the same cycle
    res_ready = 1'b1;
    BS_DONE[0] = 1'b1;
    opt_id[0] = 32'h21;
    ap_return[0] = $urandom;
    push_exp(0, {32'h21, ap_return[0]});
    step();
    opt_id[0] = 32'h22;
    ap_return[0] = $urandom;
    push_exp(0, {32'h22, ap_return[0]});
    step();
    BS_DONE = '0;
    check("recap_slot_busy", 64'(slot_free[0]), 64'd0);
    step();
    step();
    check("recap_overflow0", 64'(overflow[0]), 64'd0);
    drain("recap");

    // Reset mid-stream: 3 queued, core 0 pending
    res_ready = 1'b0;
    issue(0, 32'h301, $urandom);
    issue(1, 32'h302, $urandom);
    issue(0, 32'h303, $urandom);
    step();
    step();
    step();
    BS_DONE[0] = 1'b1;
    opt_id[0] = 32'h304;
    ap_return[0] = $urandom;
    step();
    BS_DONE = '0;
    check("mid_pre_slot_free", 64'(slot_free), 64'h2);
    check("mid_pre_valid", 64'(res_valid), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_count = 0;
    check("mid_valid", 64'(res_valid), 64'd0);
    check("mid_slot_free", 64'(slot_free), 64'h3);
    check("mid_count", 64'(result_count), 64'd0);
    check("mid_overflow", 64'(overflow), 64'd0);
    res_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check("mid_no_stale", 64'(res_valid), 64'd0);
    end

    // Randomised dispatch with random back-pressure
    for (int c = 0; c < 400; c++) begin
      res_ready = ($urandom_range(0, 3) != 0);
      BS_DONE = '0;
      for (int i = 0; i < 2; i++) begin
        if (slot_free[i] && ($urandom_range(0, 1) == 1)) begin
          rid = $urandom;
          rpr = $urandom;
          BS_DONE[i]   = 1'b1;
          opt_id[i]    = rid;
          ap_return[i] = rpr;
          push_exp(i, {rid, rpr});
        end
      end
      step();
    end
    BS_DONE = '0;
    drain("rand");
    check("rand_overflow", 64'(overflow), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bs_result_collector.md
Name: bs_result_collector

Overview:
- Collects finished Black-Scholes results from BSMODS pricing cores and serialises them onto one outbound stream.
- Sits downstream of the BS container. It consumes each core's BS_DONE pulse, ap_return and the opt_id register from that core's parameter parser.
- Each core has a one-entry holding register. A round-robin arbiter moves held results into a FIFO, which feeds a valid/ready output toward the packet transmitter.
- Emits per-core slot_free so the dispatcher never starts a core whose previous result is still held.

Parameters:
- BSMODS, 2, number of pricing cores (>=1).
- FIFO_DEPTH, 4, result FIFO entries (power of two, >=2).
- CNTW, 16, width of the delivered-result counter.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- BS_DONE  input  [BSMODS-1:0]  per-core one-cycle completion pulse.
- ap_return  input  [BSMODS-1:0][31:0]  per-core price result; valid only in the BS_DONE cycle.
- opt_id  input  [BSMODS-1:0][31:0]  per-core option id; valid in the BS_DONE cycle.
- slot_free  output  [BSMODS-1:0]  core i's holding register is empty. Dispatcher may assert BS_START[i] only while this is high.
- res_valid  output  1  res_data/res_core valid.
- res_ready  input  1  downstream accepts; transfer when res_valid & res_ready.
- res_data  output  64  {opt_id[31:0], price[31:0]}.
- res_core  output  $clog2(BSMODS) (min 1)  index of the producing core.
- overflow  output  [BSMODS-1:0]  sticky: a result from core i was dropped.
- result_count  output  CNTW  number of results delivered.

Behaviour:
- Reset (synchronous, active-high):
  - Clears pend[], holding registers, FIFO pointers/count, RR pointer (to 0), overflow and result_count.
  - Outputs after reset: slot_free all 1s, res_valid 0, res_data 0, res_core 0, overflow 0, result_count 0.
  - Reset mid-operation discards all held and queued results. No output transfer occurs in the reset cycle.
- Capture, per core i:
  - BS_DONE[i] & !pend[i]: latch {opt_id[i], ap_return[i]} and set pend[i].
  - BS_DONE[i] & pend[i] & grant[i] in the same cycle: latch the new result and keep pend[i]=1 (no loss).
  - BS_DONE[i] & pend[i] & !grant[i]: drop the new result, set overflow[i]; the held value is unchanged.
- slot_free[i] = !pend[i], driven combinationally from the register.
- Arbiter (combinational grant, registered effect):
  - space = (fifo_count < FIFO_DEPTH) | pop, where pop = res_valid & res_ready.
  - If space and any pend[]: grant the first pending core searching from rr_ptr upward, with wrap. At most one grant per cycle.
  - On a grant: write {held data, core index} to the FIFO, clear pend[g] unless recaptured, and set rr_ptr = (g+1) mod BSMODS.
  - No grant: rr_ptr holds.
- FIFO:
  - First-word-fall-through: res_valid = (fifo_count != 0). res_data/res_core show the head entry. Head is held stable while res_valid & !res_ready.
  - Push and pop in the same cycle: count unchanged; legal when full.
  - Pointers wrap modulo FIFO_DEPTH.
  - Never overflows; back-pressure propagates to pend[] and then slot_free.
- result_count increments by 1 on each pop and wraps modulo 2^CNTW.
- Latency: BS_DONE in cycle T with an idle collector gives pend at T+1, FIFO write at the end of T+1, and res_valid at T+2. Sustained throughput is one result per cycle.
- Arithmetic: no width changes; data passes through untouched.

Test Plan:
- Single result: BS_DONE[0] with opt_id=0x00000011, ap_return=0x42C80000, res_ready=1 -> res_valid at T+2 with res_data=0x0000001142C80000, res_core=0; result_count=1; slot_free[0] low during T+1 only.
- Simultaneous done: BS_DONE=2'b11, ids 0xA/0xB, rr_ptr=0, res_ready=1 -> core 0 emitted at T+2, core 1 at T+3; rr_ptr ends at 0; no overflow.
- Back-pressure: res_ready=0, 6 sequential results alternating cores (each started only when slot_free) -> FIFO holds 4 and both pend set, so slot_free=2'b00. Raise res_ready -> all 6 delivered in issue order per core; result_count=6.
- Overflow: fill FIFO with res_ready=0, pend[1]=1, then BS_DONE[1] with id 0x99 -> overflow[1]=1 and id 0x99 never appears; held result delivered after res_ready=1.
- Grant/recapture same cycle: pend[0] granted while a new BS_DONE[0] (id 0x22) arrives -> both results delivered, overflow[0]=0.
- Reset mid-stream: reset with 3 queued results and pend=2'b01 -> next cycle res_valid=0, slot_free=2'b11, result_count=0, overflow=0; no stale data emitted afterwards.
